// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Two-master request/ack bus plus the memory data port.
//  Revision    : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    logic          lock1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1, lock1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_wdata, mem_write
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1, lock1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_wdata, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the memory data port between two masters. Optional
//                MEM_ARB_ROUND_ROBIN_EN alternates ports on contention.
//  Revision    : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic elig0, elig1, cand0, win, win_port;

    // The port being acked in RESP still holds req high, so it sits out this round.
    always_comb begin : p_arb
        elig0 = bus.req0 && !((state_q == RESP) && !grant_q);
        elig1 = bus.req1 && !((state_q == RESP) && grant_q);
        cand0 = elig0 && !(bus.lock1 && last_grant_q);
        win   = cand0 || elig1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_port = (cand0 && elig1) ? ~last_grant_q : elig1;
`else
        win_port = ~cand0;
`endif
    end

    always_comb begin : p_next
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE, RESP: begin
                if (win) begin
                    grant_d      = win_port;
                    last_grant_d = win_port;
                    we_d         = win_port ? bus.we1    : bus.we0;
                    addr_d       = win_port ? bus.addr1  : bus.addr0;
                    wdata_d      = win_port ? bus.wdata1 : bus.wdata0;
                    state_d      = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (grant_q) rdata1_d = bus.mem_rdata;
                    else         rdata0_d = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Gating by reset keeps an interrupted write from committing at the reset edge.
    assign bus.mem_write = (state_q == ACCESS) && we_q && !reset;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = (state_q == RESP) && !grant_q;
    assign bus.ack1      = (state_q == RESP) && grant_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port (addr[11:0], write_data, write, data) of the unified memory between two masters.
  - Port 0: the CPU load/store unit.
  - Port 1: the program loader/debug master.
- Registers the winning request, drives the memory for one access cycle, then returns a registered response with a one-cycle ack.
- Sits between the core/loader and the memory data port. The instruction port is untouched.

Parameters:
- AW, 12, memory word-address width (drives mem_addr).
- DW, 32, data width.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 completion pulse, one cycle.
- rdata0  out  DW  port 0 read data; valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1: same roles for port 1.
- lock1  in  1  port 1 bus lock for burst loads.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory write_data.
- mem_write  out  1  to memory write.
- mem_rdata  in  DW  from memory data; combinational read of mem_addr.

Behaviour:
- Reset values:
  - state = IDLE.
  - ack0/ack1 = 0.
  - rdata0/rdata1 = 0.
  - mem_addr/mem_wdata = 0.
  - mem_write = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and RESP. On a win, the arbiter latches the port id and that port's we/addr/wdata into internal registers, then moves to ACCESS. With no eligible request it goes to (or stays in) IDLE.
- Eligibility:
  - In RESP, the port currently being acked is not eligible. Its req is still high that cycle.
  - A port re-requesting after its ack competes from the next arbitration point.
- Default priority is fixed: port 0 wins when both are eligible.
- Lock: if lock1 = 1 and last_grant = 1, port 0 is blocked. Port 1 is served whenever it is eligible. Port 0 waits until lock1 falls.
- ACCESS (one cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_write = latched we.
  - The write commits at the closing edge.
  - On a read, mem_rdata is captured into the granted port's rdata register at the closing edge.
  - Next state is RESP.
- RESP (one cycle):
  - ack of the granted port is 1; the other ack is 0.
  - On a write, rdata of the granted port is unchanged.
  - Arbitration for the next access happens in this cycle (see above).
- Latency: req sampled at edge E puts ACCESS in cycle E+1 and ack in cycle E+2. Back-to-back alternating ports give one access per 2 cycles.
- mem_write is 0 in IDLE and RESP.
- Reset mid-operation:
  - mem_write is combinationally gated by ~reset, so no write commits at a reset edge.
  - Next state is IDLE.
  - No ack is issued for the aborted transaction.
- Requests with req dropped before ack are not cancelled once latched; the ack is still issued.
- Simultaneous req0 and req1 in IDLE: port 0 wins unless it is blocked by lock1.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: on contention, the port not equal to last_grant wins, so the two ports alternate. lock1 still overrides when active.
- Not defined: fixed priority, port 0 first.

Test Plan:
- Port 0 write, addr 0x001, data 0xBB, then port 0 read addr 0x001 -> first ack0 at cycle 2; read ack0 with rdata0 = 0xBB; ack1 stays 0 throughout.
- req0 and req1 both rise in the same cycle; port 0 writes 0x10 = 0xFF, port 1 reads 0x10 -> ack0 first; ack1 two cycles later with rdata1 = 0xFF. With MEM_ARB_ROUND_ROBIN_EN and last_grant = 0, ack1 comes first and rdata1 is the old value.
- lock1 = 1 while port 1 writes 0x20..0x23 back-to-back and req0 is held high -> the four ack1 pulses all precede ack0; ack0 arrives 2 cycles after the first arbitration with lock1 = 0.
- Reset asserted during a port 1 ACCESS write of 0x55 to addr 0x30 -> no ack1; a later read of 0x30 returns the pre-reset value; all outputs are 0 after reset.
- Port 1 read in flight and req1 dropped right after latch -> ack1 still pulses once with valid rdata1; no second access follows.
- Idle with no req for 10 cycles -> mem_write = 0 and both acks = 0 every cycle.
